// File: rtl/fdst7_pkg.sv
// Shared types, constants and saturation helper for the forward 4-point DST-VII engine.
package fdst7_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  localparam int PKG_ACC_W = 32;

  typedef logic signed [7:0] coef8_t;

  localparam coef8_t DST7_4_COEF [4][4] = '{
    '{ 8'sd29,  8'sd55,  8'sd74,  8'sd84},
    '{ 8'sd74,  8'sd74,  8'sd0,  -8'sd74},
    '{ 8'sd84, -8'sd29, -8'sd74,  8'sd55},
    '{ 8'sd55, -8'sd84,  8'sd74, -8'sd29}
  };

  // Clamp v into the signed range of a w-bit integer, result kept in accumulator width.
  function automatic logic signed [PKG_ACC_W-1:0] sat(input logic signed [PKG_ACC_W-1:0] v,
                                                      input int w);
    logic signed [PKG_ACC_W-1:0] hi;
    logic signed [PKG_ACC_W-1:0] lo;
    hi = (PKG_ACC_W'(1) <<< (w - 1)) - PKG_ACC_W'(1);
    lo = -hi - PKG_ACC_W'(1);
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fdst7_mul_8s_32s.sv
// Registered signed 8x32 multiplier, one cycle of latency, product truncated to 32 bits.
module fdst7_mul_8s_32s (
  input  logic               clk,
  input  logic               ce,
  input  logic signed [7:0]  din0,
  input  logic signed [31:0] din1,
  output logic signed [31:0] dout
);

  logic signed [31:0] din0_ext;

  assign din0_ext = 32'(din0);

  always_ff @(posedge clk) begin
    if (ce) begin
      dout <= din0_ext * din1;
    end
  end

endmodule

// File: rtl/fdst7_4pt_engine.sv
// Forward 4-point DST-VII: one shared MAC walks the 16 matrix products of a row in
// row-major order, rounding and saturating each coefficient as its last product lands.
module fdst7_4pt_engine
  import fdst7_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*IN_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*OUT_W-1:0] out_data
);

  state_t                   state_q, state_d;
  logic                     rst_ok_q;
  logic [3:0]               idx_q, idx_d;
  logic signed [IN_W-1:0]   x_q [4];
  logic                     pv_q;
  logic [3:0]               ptag_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [OUT_W-1:0]  coef_q [4];
  coef8_t                   coef_sel;
  logic                     mul_ce;

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] bias;
    bias = ACC_W'(1) <<< (SHIFT - 1);
    return (v + bias) >>> SHIFT;
  endfunction

  assign in_ready  = (state_q == IDLE) && rst_ok_q;
  assign out_valid = (state_q == OUT);
  assign mul_ce    = (state_q == MAC) || (state_q == DRAIN);

  // Operand select for the product issued this cycle.
  assign coef_sel = DST7_4_COEF[idx_q[3:2]][idx_q[1:0]];
  assign x_ext    = ACC_W'(x_q[idx_q[1:0]]);

  fdst7_mul_8s_32s u_mul (
    .clk  (clk),
    .ce   (mul_ce),
    .din0 (coef_sel),
    .din1 (x_ext),
    .dout (prod)
  );

  // The first product of each coefficient restarts the running sum.
  assign sum = (ptag_q[1:0] == 2'd0) ? prod : (acc_q + prod);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = MAC;
          idx_d   = 4'd0;
        end
      end
      MAC: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: the tag follows the product through the multiplier register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rst_ok_q <= 1'b0;
      idx_q    <= 4'd0;
      pv_q     <= 1'b0;
      ptag_q   <= 4'd0;
      acc_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        coef_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rst_ok_q <= 1'b1;
      idx_q    <= idx_d;
      pv_q     <= (state_q == MAC);
      ptag_q   <= idx_q;
      if (pv_q) begin
        acc_q <= sum;
        if (ptag_q[1:0] == 2'd3) begin
          coef_q[ptag_q[3:2]] <= OUT_W'(sat(round_shift(sum), OUT_W));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int n = 0; n < 4; n++) begin
        x_q[n] <= in_data[n*IN_W +: IN_W];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*OUT_W +: OUT_W] = coef_q[k];
    end
  end

endmodule
